// File: rtl/adc_serial_reader.sv
// ---------------------------------------------------------------------------
// adc_serial_reader
//
// Acquisition front end for the voltage-monitor unit. Runs a serial ADC in
// continuous-conversion mode: drops chip select, generates the bit clock,
// shifts in the MSB-first result, keeps the last DATA_BITS bits of each
// frame and box-car averages 2^AVG_LOG2 frames into a 16-bit result.
//
// Ports:
//   clk        in   system clock, the only clock
//   rst        in   synchronous, active-high reset
//   en         in   continuous-conversion enable, checked at frame boundaries
//   ad_in      in   ADC serial data, MSB first, sampled on adclk rise
//   adclk      out  ADC bit clock, idles low
//   cs_n       out  ADC chip select, active low
//   volt       out  averaged conversion result, zero-extended to 16 bits
//   volt_valid out  one-cycle strobe when volt takes a new value
//
// Parameters:
//   CLK_DIV    clk cycles per adclk half-period (>= 2)
//   FRAME_BITS adclk pulses per conversion frame
//   DATA_BITS  result bits at the tail of the frame (2..16, <= FRAME_BITS)
//   GAP_CYCLES clk cycles cs_n stays high between frames (>= 1)
//   AVG_LOG2   log2 of the number of frames averaged (0..4, 0 = pass-through)
// ---------------------------------------------------------------------------
module adc_serial_reader #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int GAP_CYCLES = 8,
  parameter int AVG_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ad_in,
  output logic        adclk,
  output logic        cs_n,
  output logic [15:0] volt,
  output logic        volt_valid
);

  // One shared cycle counter times SETUP, each adclk half-period and the
  // HOLD gap, so it must reach whichever of CLK_DIV / GAP_CYCLES is larger.
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int ACC_W   = 16 + AVG_LOG2;
  localparam int FCNT_W  = AVG_LOG2 + 1;
  localparam int AVG_N   = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } stateType;

  stateType               r_state;
  stateType               w_nextState;

  logic [CNT_W-1:0]       r_cycCnt;
  logic [BIT_W-1:0]       r_bitCnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_sampleDone;
  logic                   r_emitPending;
  logic [ACC_W-1:0]       r_acc;
  logic [FCNT_W-1:0]      r_frameCnt;

  logic                   r_adclk;
  logic                   r_csN;
  logic [15:0]            r_volt;
  logic                   r_voltValid;

  logic                   w_phaseDone;
  logic                   w_gapDone;
  logic                   w_lastBit;
  logic                   w_cntClear;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_dropGroup;
  logic                   w_adclkNext;
  logic                   w_csNNext;
  logic [15:0]            w_accAvg;

  // Terminal-count decodes for the shared counter and the bit counter.
  assign w_phaseDone = (r_cycCnt == CNT_W'(CLK_DIV - 1));
  assign w_gapDone   = (r_cycCnt == CNT_W'(GAP_CYCLES - 1));
  assign w_lastBit   = (r_bitCnt == BIT_W'(FRAME_BITS - 1));

  // Dividing by 2^AVG_LOG2 is just dropping the low accumulator bits; the
  // remaining slice is exactly 16 bits wide for every legal AVG_LOG2.
  assign w_accAvg = r_acc[ACC_W-1:AVG_LOG2];

  // State register together with the registered pin drivers, so cs_n and
  // adclk change on the same edge as the state they belong to. Reset parks
  // both pins idle immediately, which also kills any half-finished adclk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_csN   <= 1'b1;
      r_adclk <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_csN   <= w_csNNext;
      r_adclk <= w_adclkNext;
    end
  end

  // Next-state logic. SETUP lasts one half-period, SHIFT ends on the falling
  // edge that closes the last bit, and HOLD is where en is finally looked at
  // so that dropping en never truncates a frame.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (en) w_nextState = SETUP;
      end
      SETUP: begin
        if (w_phaseDone) w_nextState = SHIFT;
      end
      SHIFT: begin
        if (r_adclk && w_phaseDone && w_lastBit) w_nextState = HOLD;
      end
      HOLD: begin
        if (w_gapDone) w_nextState = en ? SETUP : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output and datapath-control decode. Chip select follows the state being
  // entered, so it falls on the same edge that leaves IDLE/HOLD and rises on
  // the edge that enters HOLD. Inside SHIFT adclk toggles at every half-period
  // terminal count, which gives the low-then-high shape of each bit period.
  always_comb begin
    w_csNNext   = (w_nextState == IDLE) || (w_nextState == HOLD);
    w_adclkNext = 1'b0;
    w_cntClear  = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_dropGroup = 1'b0;
    case (r_state)
      IDLE: begin
        w_cntClear = 1'b1;
      end
      SETUP: begin
        w_cntClear = w_phaseDone;
      end
      SHIFT: begin
        w_adclkNext = r_adclk ^ w_phaseDone;
        w_cntClear  = w_phaseDone;
        w_rise      = !r_adclk && w_phaseDone;
        w_fall      = r_adclk && w_phaseDone;
      end
      HOLD: begin
        w_cntClear  = w_gapDone;
        w_dropGroup = w_gapDone && !en;
      end
      default: begin
        w_cntClear = 1'b1;
      end
    endcase
  end

  // Shared cycle counter: restarts at every phase boundary.
  always_ff @(posedge clk) begin
    if (rst || w_cntClear) begin
      r_cycCnt <= '0;
    end else begin
      r_cycCnt <= r_cycCnt + 1'b1;
    end
  end

  // Bit counter advances on each adclk fall and wraps after the final bit,
  // so it is already zero when the next frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitCnt <= '0;
    end else if (w_fall) begin
      r_bitCnt <= w_lastBit ? '0 : r_bitCnt + 1'b1;
    end
  end

  // Capture ad_in on the edge that raises adclk. Only DATA_BITS of history
  // are kept, so the leading frame bits fall off the top by themselves.
  // The sample-done flag marks the edge that took the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_sampleDone <= 1'b0;
    end else begin
      r_sampleDone <= w_rise && w_lastBit;
      if (w_rise) begin
        r_shift <= {r_shift[DATA_BITS-2:0], ad_in};
      end
    end
  end

  // Averaging: one edge after the final sample the frame is added in; if it
  // was the last frame of the group the result is published one edge later
  // and the group restarts. A frame sequence broken by en going low is
  // thrown away when the FSM falls back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc         <= '0;
      r_frameCnt    <= '0;
      r_emitPending <= 1'b0;
      r_volt        <= '0;
      r_voltValid   <= 1'b0;
    end else begin
      r_voltValid   <= 1'b0;
      r_emitPending <= r_sampleDone && (r_frameCnt == FCNT_W'(AVG_N - 1));
      if (r_emitPending) begin
        r_volt      <= w_accAvg;
        r_voltValid <= 1'b1;
        r_acc       <= '0;
        r_frameCnt  <= '0;
      end else if (r_sampleDone) begin
        r_acc      <= r_acc + ACC_W'(r_shift);
        r_frameCnt <= r_frameCnt + 1'b1;
      end else if (w_dropGroup) begin
        r_acc      <= '0;
        r_frameCnt <= '0;
      end
    end
  end

  assign adclk      = r_adclk;
  assign cs_n       = r_csN;
  assign volt       = r_volt;
  assign volt_valid = r_voltValid;

endmodule
